progmem_arbiter: RTL and testbench
==================================

Name: progmem_arbiter

Overview:
- Two-port read arbiter in front of the program-memory wrapper: port A (instruction fetch), port B (debug/loader/data read).
- Shares the single ROM read port with round-robin fairness and holds each grant until the downstream read completes.
- Adds an out-of-range address check, a downstream timeout, and a guaranteed idle gap between downstream reads so the wrapper's wait counter re-arms.
- Sits between the CPU/debug masters and the progmem wrapper on the same clock.

Parameters:
- ADDR_W, 10, word address width on all ports (12 for the Spartan-7 build).
- DATA_W, 32, read data width.
- ROM_WORDS, 1024, number of valid words; any address >= ROM_WORDS is a decode error.
- TIMEOUT, 15, max cycles in BUSY with m_waitrequest high before error completion.
- TO_W, 4, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- a_address  in  ADDR_W  port A word address.
- a_read  in  1  port A read request, held until a_waitrequest is low.
- a_readdata  out  DATA_W  port A read data, valid when a_read=1 and a_waitrequest=0.
- a_response  out  2  port A response: 00 OK, 10 SLAVEERROR, 11 DECODEERROR.
- a_waitrequest  out  1  port A stall.
- b_address, b_read, b_readdata, b_response, b_waitrequest: same as port A, for port B.
- m_address  out  ADDR_W  to the wrapper's ctrl_address.
- m_read  out  1  to ctrl_read.
- m_readdata  in  DATA_W  from ctrl_readdata.
- m_response  in  2  from ctrl_response.
- m_waitrequest  in  1  from ctrl_waitrequest.

Behaviour:
- States: IDLE, BUSY, DECERR.
- Registers: grant (0=A, 1=B), last (port last served), addr_q, to_cnt.
- Reset values: state=IDLE, grant=0, last=1 (so A wins the first tie), addr_q=0, to_cnt=0, m_read=0, m_address=0.
- Reset value of port outputs: every *_waitrequest equals its *_read with no completion; *_readdata=0; *_response=00.
- IDLE:
  - m_read=0.
  - If only one port requests, grant it. If both request, grant the port other than last.
  - Latch the granted address into addr_q.
  - Go to DECERR if addr >= ROM_WORDS, else go to BUSY with to_cnt=0.
  - No request: stay in IDLE.
- BUSY:
  - m_read=1, m_address=addr_q.
  - m_waitrequest=0 is completion: the granted port sees waitrequest=0 that cycle, readdata=m_readdata and response=m_response, both combinational pass-through. Then last=grant and go to IDLE.
  - m_waitrequest=1: to_cnt increments. When to_cnt==TIMEOUT and m_waitrequest is still 1, complete with readdata=0 and response=10, drop m_read, then go to IDLE.
- DECERR:
  - One cycle; m_read stays 0.
  - Granted port completes with readdata=0 and response=11. Then last=grant and go to IDLE.
- The non-granted port always sees waitrequest = its read. Its readdata and response are 0.
- Requester drops read while granted (protocol violation): abort, m_read=0 next cycle, go to IDLE, last unchanged, no completion issued.
- Every downstream transaction is followed by at least one IDLE cycle with m_read=0. The wrapper's wait counter only clears when its read is low.
- Latency with the current wrapper (2 wait cycles):
  - Request seen in IDLE at cycle 0.
  - BUSY at cycles 1–3.
  - Completion at cycle 3 after request, i.e. 4 cycles total.
  - Back-to-back from one port: next completion 4 cycles later.
- Simultaneous new requests at completion are resolved in the following IDLE cycle using the updated last.
- Reset asserted mid-transaction: immediate return to IDLE, m_read=0, no completion issued.

Decomposition:
- Shared package progmem_pkg holds:
  - response codes RESP_OK=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - state encoding for IDLE/BUSY/DECERR;
  - default ROM_WORDS per target (1024, or 4096 for Spartan-7).
- One natural sub-module: rr_arb2, a two-requester round-robin grant picker, combinational with a registered last pointer.
- Top level is a flat FSM.

Test Plan:
- Single A read of addr 0x005 with the wrapper model returning 0xDEADBEEF after 2 waits -> a_waitrequest drops at cycle 3, a_readdata=0xDEADBEEF, a_response=00, m_read low the following cycle.
- A and B assert together at addr 0x010/0x020 after reset -> A served first, then B. Next simultaneous pair -> B served first (alternation). No back-to-back m_read without a gap.
- B reads addr 0x3FF with ROM_WORDS=1000 -> DECERR: b_waitrequest low at cycle 1, b_response=11, m_read never asserts.
- Wrapper model holds m_waitrequest high forever -> completion after 16 BUSY cycles with a_response=10 and a_readdata=0. Next request is served normally.
- A drops a_read in the 2nd BUSY cycle -> m_read=0 next cycle, no completion. A pending B request is granted in the following IDLE cycle.
- rst_n pulsed low during BUSY -> m_read=0 asynchronously, state IDLE. First post-reset tie is granted to A.

Source files
------------

// File: rtl/progmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : progmem_pkg
//  Description : Shared types and constants for the program-memory read
//                arbiter: response codes, FSM state encoding and the default
//                ROM depth for each build target.
//  Revision    : 1.0 - initial release
// ============================================================================
package progmem_pkg;

    // Avalon-style response codes returned with every completed read.
    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OK     = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUSY   = 2'b01,
        ST_DECERR = 2'b10
    } state_t;

    // Number of valid ROM words per build target.
    localparam int ROM_WORDS_DEFAULT = 1024;
    localparam int ROM_WORDS_S7      = 4096;

    function automatic int rom_words_for(input bit spartan7);
        return spartan7 ? ROM_WORDS_S7 : ROM_WORDS_DEFAULT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/progmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : progmem_arbiter_if
//  Description : Word-addressed read bus used on both arbiter request ports
//                and on the downstream program-memory wrapper port.
//                  address     : word address            (master -> slave)
//                  read        : read request, held while waitrequest=1
//                  readdata    : data, valid when read=1 and waitrequest=0
//                  response    : 00 OK, 10 SLAVEERROR, 11 DECODEERROR
//                  waitrequest : stall                    (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface progmem_arbiter_if
    import progmem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic [DATA_W-1:0] readdata;
    resp_t             response;
    logic              waitrequest;

    modport master (
        output address,
        output read,
        input  readdata,
        input  response,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read,
        output readdata,
        output response,
        output waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-requester round-robin grant picker. The pick is purely
//                combinational; only the "last served" pointer is registered.
//  Ports       : clk, rst_n   - clock, asynchronous active-low reset
//                req[1:0]     - request from requester 0 (A) and 1 (B)
//                update       - a grant completed this cycle
//                served       - index of the requester that completed
//                gnt_valid    - at least one requester is asking
//                gnt_idx      - requester picked this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [1:0] req,
    input  wire logic       update,
    input  wire logic       served,
    output logic            gnt_valid,
    output logic            gnt_idx
);

    logic r_last;

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~r_last;
        end else begin
            gnt_idx = req[1];
        end
    end

    // Reset to B so that requester A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (update) begin
            r_last <= served;
        end
    end

endmodule
`default_nettype wire

// File: rtl/progmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : progmem_arbiter
//  Description : Two-port read arbiter in front of the program-memory wrapper.
//                Port A is instruction fetch, port B is debug/loader/data.
//                Round-robin sharing of the single ROM read port, grant held
//                until the downstream read completes, address range check,
//                downstream timeout, and a forced idle cycle between
//                downstream reads so the wrapper's wait counter re-arms.
//  Ports       : clk, rst_n - clock, asynchronous active-low reset
//                a          - port A requester bus (slave side)
//                b          - port B requester bus (slave side)
//                m          - downstream wrapper bus (master side)
//  Revision    : 1.0 - initial release
// ============================================================================
module progmem_arbiter
    import progmem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int ROM_WORDS = ROM_WORDS_DEFAULT,
    parameter int TIMEOUT   = 15,
    parameter int TO_W      = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    progmem_arbiter_if.slave   a,
    progmem_arbiter_if.slave   b,
    progmem_arbiter_if.master  m
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            r_state;
    logic              r_grant;      // 0 = A, 1 = B
    logic [ADDR_W-1:0] r_addr_q;     // latched granted address, drives m.address
    logic [TO_W-1:0]   r_to_cnt;     // BUSY cycles spent waiting
    logic              r_m_read;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic              w_req_valid;
    logic              w_pick;
    logic [ADDR_W-1:0] w_pick_addr;
    logic              w_pick_oor;
    logic              w_gnt_read;
    logic              w_timeout;
    logic              w_done;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({b.read, a.read}),
        .update    (w_done),
        .served    (r_grant),
        .gnt_valid (w_req_valid),
        .gnt_idx   (w_pick)
    );

    assign w_pick_addr = w_pick ? b.address : a.address;

    // When the ROM fills the whole address space no address can be out of
    // range, and the compare constant would not fit in ADDR_W bits.
    generate
        if (ROM_WORDS >= (1 << ADDR_W)) begin : g_full_map
            assign w_pick_oor = 1'b0;
        end else begin : g_part_map
            assign w_pick_oor = (w_pick_addr >= ADDR_W'(ROM_WORDS));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Completion detection
    // ------------------------------------------------------------------------
    // A granted requester that has dropped read gets no completion at all;
    // the FSM treats that as an abort.
    assign w_gnt_read = r_grant ? b.read : a.read;
    assign w_timeout  = (r_state == ST_BUSY) && m.waitrequest &&
                        (r_to_cnt == TO_W'(TIMEOUT));
    assign w_done     = w_gnt_read &&
                        (((r_state == ST_BUSY) && (!m.waitrequest || w_timeout)) ||
                         (r_state == ST_DECERR));

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= 1'b0;
            r_addr_q <= '0;
            r_to_cnt <= '0;
            r_m_read <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // m.read is always low for at least this one cycle,
                    // which lets the wrapper clear its wait counter.
                    r_m_read <= 1'b0;
                    if (w_req_valid) begin
                        r_grant  <= w_pick;
                        r_addr_q <= w_pick_addr;
                        r_to_cnt <= '0;
                        if (w_pick_oor) begin
                            r_state <= ST_DECERR;
                        end else begin
                            r_state  <= ST_BUSY;
                            r_m_read <= 1'b1;
                        end
                    end
                end

                ST_BUSY: begin
                    if (!w_gnt_read || w_done) begin
                        r_state  <= ST_IDLE;
                        r_m_read <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                ST_DECERR: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_m_read <= 1'b0;
                end
            endcase
        end
    end

    assign m.read    = r_m_read;
    assign m.address = r_addr_q;

    // ------------------------------------------------------------------------
    // Completion payload and port outputs
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] w_cpl_data;
    resp_t             w_cpl_resp;
    logic              w_done_a;
    logic              w_done_b;

    // Downstream data and response pass straight through on a normal
    // completion; error completions carry zero data.
    always_comb begin
        w_cpl_data = '0;
        w_cpl_resp = RESP_OK;
        if (r_state == ST_DECERR) begin
            w_cpl_resp = RESP_DECERR;
        end else if (w_timeout) begin
            w_cpl_resp = RESP_SLVERR;
        end else begin
            w_cpl_data = m.readdata;
            w_cpl_resp = m.response;
        end
    end

    assign w_done_a = w_done && !r_grant;
    assign w_done_b = w_done &&  r_grant;

    assign a.waitrequest = a.read && !w_done_a;
    assign a.readdata    = w_done_a ? w_cpl_data : '0;
    assign a.response    = w_done_a ? w_cpl_resp : RESP_OK;

    assign b.waitrequest = b.read && !w_done_b;
    assign b.readdata    = w_done_b ? w_cpl_data : '0;
    assign b.response    = w_done_b ? w_cpl_resp : RESP_OK;

endmodule
`default_nettype wire

// File: tb/tb_progmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_progmem_arbiter
//  Description : Self-checking bench for progmem_arbiter. Directed requests
//                push hand-computed completions into a scoreboard; a monitor
//                pops and compares whenever a port completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_progmem_arbiter;
    import progmem_pkg::*;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int ROM_WORDS = 1000;
    localparam int TIMEOUT   = 15;
    localparam int TO_W      = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    progmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_if ();
    progmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_if ();
    progmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_if ();

    progmem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ROM_WORDS (ROM_WORDS),
        .TIMEOUT   (TIMEOUT),
        .TO_W      (TO_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a_if),
        .b     (b_if),
        .m     (m_if)
    );

    // Requester drive
    logic [ADDR_W-1:0] a_address, b_address;
    logic              a_read, b_read;
    assign a_if.address = a_address;
    assign a_if.read    = a_read;
    assign b_if.address = b_address;
    assign b_if.read    = b_read;

    // Wrapper model: 2 wait cycles, counter clears only while read is low.
    logic [1:0] wcnt = 2'd0;
    logic       hang;
    logic [1:0] force_resp;

    function automatic logic [31:0] memfn(input logic [ADDR_W-1:0] ad);
        return (ad == 10'h005) ? 32'hDEADBEEF : (32'hA500_0000 | {22'd0, ad});
    endfunction

    always @(posedge clk) begin
        if (!m_if.read)          wcnt <= 2'd0;
        else if (wcnt != 2'd2)   wcnt <= wcnt + 2'd1;
    end
    assign m_if.waitrequest = hang || (wcnt != 2'd2);
    assign m_if.readdata    = memfn(m_if.address);
    assign m_if.response    = force_resp;

    // Cycle counter
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Checking infrastructure
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        bit          port;
        logic [31:0] data;
        logic [1:0]  resp;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    task automatic push(input bit p, input logic [31:0] d, input logic [1:0] r, input int c);
        exp_t e;
        e.port = p; e.data = d; e.resp = r; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input bit p, input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("cpl_port",  64'(p),   64'(e.port));
            check("cpl_data",  64'(d),   64'(e.data));
            check("cpl_resp",  64'(r),   64'(e.resp));
            check("cpl_cycle", 64'(cyc), 64'(e.cyc));
        end
    endtask

    // Monitor
    logic mread_forbid;
    initial begin : monitor
        logic prev_cpl, cpl_a, cpl_b;
        prev_cpl = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_m",  64'({m_if.read, m_if.address}), 64'd0);
                check("rst_a",  64'({a_if.waitrequest, a_if.response, a_if.readdata}),
                                64'({a_read, 2'b00, 32'd0}));
                check("rst_b",  64'({b_if.waitrequest, b_if.response, b_if.readdata}),
                                64'({b_read, 2'b00, 32'd0}));
                prev_cpl = 1'b0;
            end else begin
                if (prev_cpl)     check("gap_mread",    64'(m_if.read), 64'd0);
                if (mread_forbid) check("mread_forbid", 64'(m_if.read), 64'd0);
                cpl_a = a_read && !a_if.waitrequest;
                cpl_b = b_read && !b_if.waitrequest;
                if (cpl_a) sb_pop(1'b0, a_if.readdata, a_if.response);
                else check("a_idle_zero", 64'({a_if.response, a_if.readdata}), 64'd0);
                if (cpl_b) sb_pop(1'b1, b_if.readdata, b_if.response);
                else check("b_idle_zero", 64'({b_if.response, b_if.readdata}), 64'd0);
                prev_cpl = cpl_a || cpl_b;
            end
        end
    end

    // Advance one cycle; a requester drops read after its completion.
    task automatic step();
        logic ca, cb;
        @(negedge clk);
        ca = a_read && !a_if.waitrequest;
        cb = b_read && !b_if.waitrequest;
        @(posedge clk);
        #1;
        if (ca) a_read = 1'b0;
        if (cb) b_read = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((a_read || b_read) && n < budget) begin
            step();
            n++;
        end
        check("wait_budget", 64'(a_read || b_read), 64'd0);
        step();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Stimulus
    initial begin : stim
        int t;
        rst_n = 1'b0; a_read = 1'b0; b_read = 1'b0;
        a_address = '0; b_address = '0;
        hang = 1'b0; force_resp = 2'b00; mread_forbid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Tie after reset: A first; A re-requests at completion -> B next.
        t = cyc;
        a_address = 10'h010; a_read = 1'b1;
        b_address = 10'h020; b_read = 1'b1;
        push(1'b0, 32'hA500_0010, RESP_OK, t + 3);
        push(1'b1, 32'hA500_0020, RESP_OK, t + 7);
        repeat (4) step();
        a_address = 10'h011; a_read = 1'b1;
        push(1'b0, 32'hA500_0011, RESP_OK, t + 11);
        wait_idle(30);

        // Single A read of 0x005.
        t = cyc;
        a_address = 10'h005; a_read = 1'b1;
        push(1'b0, 32'hDEADBEEF, RESP_OK, t + 3);
        wait_idle(20);

        // Wrapper slave error passes straight through on B.
        force_resp = 2'b10;
        t = cyc;
        b_address = 10'h033; b_read = 1'b1;
        push(1'b1, 32'hA500_0033, RESP_SLVERR, t + 3);
        wait_idle(20);
        force_resp = 2'b00;

        // Decode error on B: one-cycle completion, no downstream read.
        mread_forbid = 1'b1;
        t = cyc;
        b_address = 10'h3FF; b_read = 1'b1;
        push(1'b1, 32'h0, RESP_DECERR, t + 1);
        wait_idle(20);
        mread_forbid = 1'b0;

        // Downstream hang: timeout after 16 BUSY cycles, then a normal read.
        hang = 1'b1;
        t = cyc;
        a_address = 10'h044; a_read = 1'b1;
        push(1'b0, 32'h0, RESP_SLVERR, t + 16);
        wait_idle(40);
        hang = 1'b0;
        t = cyc;
        b_address = 10'h030; b_read = 1'b1;
        push(1'b1, 32'hA500_0030, RESP_OK, t + 3);
        wait_idle(20);

        // A aborts in its 2nd BUSY cycle; pending B served afterwards.
        t = cyc;
        a_address = 10'h050; a_read = 1'b1;
        step();
        b_address = 10'h060; b_read = 1'b1;
        push(1'b1, 32'hA500_0060, RESP_OK, t + 6);
        step();
        a_read = 1'b0;
        step();
        mread_forbid = 1'b1;
        step();
        mread_forbid = 1'b0;
        wait_idle(20);

        // A served last, then reset mid-BUSY; first tie afterwards goes to A.
        t = cyc;
        a_address = 10'h007; a_read = 1'b1;
        push(1'b0, 32'hA500_0007, RESP_OK, t + 3);
        wait_idle(20);
        a_address = 10'h008; a_read = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        a_read = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        t = cyc;
        a_address = 10'h009; a_read = 1'b1;
        b_address = 10'h00A; b_read = 1'b1;
        push(1'b0, 32'hA500_0009, RESP_OK, t + 3);
        push(1'b1, 32'hA500_000A, RESP_OK, t + 7);
        wait_idle(30);

        step();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
